// File: rtl/int2fp_pkg.sv
// Shared constants for the int2fp converter: rounding-mode encodings and exponent sizing helpers.
package int2fp_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Holds IN_W-1 + bias plus a rounding carry without wrapping.
  function automatic int int_exp_w(input int exp_w, input int in_w);
    int lw;
    lw = $clog2(in_w);
    return ((exp_w > lw) ? exp_w : lw) + 2;
  endfunction

endpackage

// File: rtl/int2fp_lzc.sv
// Combinational leading-zero counter, log-depth pairwise tree; an all-zero input returns W.
module int2fp_lzc #(
  parameter int W = 33
) (
  input  logic [W-1:0]       value,
  output logic [$clog2(W):0] count
);

  localparam int L  = $clog2(W);
  localparam int P  = 1 << L;
  localparam int CW = L + 1;

  logic [P-1:0] pad;
  logic [L:0]   cnt [L+1][P];
  logic         hit [L+1][P];

  always_comb begin
    for (int s = 0; s <= L; s++) begin
      for (int i = 0; i < P; i++) begin
        cnt[s][i] = '0;
        hit[s][i] = 1'b0;
      end
    end
    // Ones below the operand keep the count exact for any nonzero input.
    pad = '1;
    pad[P-1 -: W] = value;
    for (int i = 0; i < P; i++) hit[0][i] = pad[i];
    for (int s = 1; s <= L; s++) begin
      for (int i = 0; i < (P >> s); i++) begin
        hit[s][i] = hit[s-1][2*i+1] | hit[s-1][2*i];
        if (hit[s-1][2*i+1]) begin
          cnt[s][i] = cnt[s-1][2*i+1];
        end else begin
          cnt[s][i] = cnt[s-1][2*i];
          cnt[s][i][s-1] = 1'b1;
        end
      end
    end
    count = hit[L][0] ? cnt[L][0] : CW'(P);
  end

endmodule

// File: rtl/int2fp_pipe.sv
// Pipelined integer to IEEE-754 converter: result 3 cycles after acceptance.
// One global advance stalls every stage while out_valid & ~out_ready; bubbles are kept.
module int2fp_pipe
  import int2fp_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_signed,
  input  logic [1:0]             in_rm,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_inexact,
  output logic                   out_overflow,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int W       = IN_W + 1;
  localparam int LW      = $clog2(W) + 1;
  localparam int XW      = int_exp_w(EXP_W, IN_W);
  localparam int BIAS    = fp_bias(EXP_W);
  localparam int NW      = (W > MAN_W + 3) ? W : MAN_W + 3;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic             p0_vld, p0_signed;
  logic [IN_W-1:0]  p0_data;
  logic [1:0]       p0_rm;
  logic [TAG_W-1:0] p0_tag;

  logic             s1_vld, s1_sign;
  logic [W-1:0]     s1_abs;
  logic [1:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_vld, s2_sign;
  logic [W-1:0]     s2_norm;
  logic [XW-1:0]    s2_exp;
  logic [1:0]       s2_rm;
  logic [TAG_W-1:0] s2_tag;

  // S1: sign and magnitude one bit wider than the operand so the most negative value fits.
  logic         neg;
  logic [W-1:0] ext, mag;
  assign neg = p0_signed & p0_data[IN_W-1];
  assign ext = {neg, p0_data};
  assign mag = neg ? -ext : ext;

  // S2: normalise so the leading one lands in the top bit.
  logic [LW-1:0] lzc;
  int2fp_lzc #(.W(W)) u_lzc (
    .value (s1_abs),
    .count (lzc)
  );

  // S3: round, renormalise, overflow and pack.
  logic [NW-1:0]      wide;
  logic [MAN_W-1:0]   stored;
  logic               nz, guard, sticky, inc, to_inf, ovf;
  logic [MAN_W:0]     rnd;
  logic [XW-1:0]      bexp;
  logic [EXP_W+MAN_W:0] pack;
  logic               res_inx, res_ovf;

  always_comb begin
    wide = '0;
    wide[NW-1 -: W] = s2_norm;
    nz     = wide[NW-1];
    stored = wide[NW-2 -: MAN_W];
    guard  = wide[NW-MAN_W-2];
    sticky = |wide[NW-MAN_W-3:0];
    case (s2_rm)
      RM_RNE:  inc = guard & (sticky | stored[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_sign & (guard | sticky);
      default: inc = ~s2_sign & (guard | sticky);
    endcase
    rnd    = {1'b0, stored} + (MAN_W+1)'(inc);
    bexp   = s2_exp + XW'(BIAS) + XW'(rnd[MAN_W]);
    ovf    = bexp >= XW'(EXP_MAX);
    to_inf = (s2_rm == RM_RNE) | ((s2_rm == RM_RDN) & s2_sign) | ((s2_rm == RM_RUP) & ~s2_sign);
    pack    = '0;
    res_inx = 1'b0;
    res_ovf = 1'b0;
    if (nz) begin
      if (ovf) begin
        res_inx = 1'b1;
        res_ovf = 1'b1;
        pack    = to_inf ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                         : {s2_sign, EXP_W'(EXP_MAX - 1), {MAN_W{1'b1}}};
      end else begin
        res_inx = guard | sticky;
        pack    = {s2_sign, bexp[EXP_W-1:0], rnd[MAN_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p0_vld       <= 1'b0;
      p0_signed    <= 1'b0;
      p0_data      <= '0;
      p0_rm        <= '0;
      p0_tag       <= '0;
      s1_vld       <= 1'b0;
      s1_sign      <= 1'b0;
      s1_abs       <= '0;
      s1_rm        <= '0;
      s1_tag       <= '0;
      s2_vld       <= 1'b0;
      s2_sign      <= 1'b0;
      s2_norm      <= '0;
      s2_exp       <= '0;
      s2_rm        <= '0;
      s2_tag       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
      out_tag      <= '0;
    end else if (adv) begin
      p0_vld       <= in_valid;
      p0_signed    <= in_signed;
      p0_data      <= in_data;
      p0_rm        <= in_rm;
      p0_tag       <= in_tag;
      s1_vld       <= p0_vld;
      s1_sign      <= neg;
      s1_abs       <= mag;
      s1_rm        <= p0_rm;
      s1_tag       <= p0_tag;
      s2_vld       <= s1_vld;
      s2_sign      <= s1_sign;
      s2_norm      <= s1_abs << lzc;
      s2_exp       <= XW'(W - 1) - XW'(lzc);
      s2_rm        <= s1_rm;
      s2_tag       <= s1_tag;
      out_valid    <= s2_vld;
      out_data     <= pack;
      out_inexact  <= res_inx;
      out_overflow <= res_ovf;
      out_tag      <= s2_tag;
    end
  end

endmodule

// File: tb/tb_int2fp_pipe.sv
// Bench for int2fp_pipe: fp32 and fp16 instances share one input stream, checked against an arithmetic model.
module tb_int2fp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_rm = '0;
  logic [3:0]  in_tag = '0;

  logic        r32_in_ready, r32_out_valid, r32_inx, r32_ovf;
  logic [31:0] r32_data;
  logic [3:0]  r32_tag;
  logic        r16_in_ready, r16_out_valid, r16_inx, r16_ovf;
  logic [15:0] r16_data;
  logic [3:0]  r16_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    bit          s;
    logic [1:0]  rm;
    logic [3:0]  tag;
  } beat_t;

  beat_t q[$];

  always #5 clk = ~clk;

  int2fp_pipe u_fp32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_data(in_data), .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_data(r32_data),
    .out_inexact(r32_inx), .out_overflow(r32_ovf), .out_tag(r32_tag)
  );

  int2fp_pipe #(.IN_W(32), .EXP_W(5), .MAN_W(10), .TAG_W(4)) u_fp16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r16_in_ready),
    .in_data(in_data), .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(r16_out_valid), .out_ready(out_ready), .out_data(r16_data),
    .out_inexact(r16_inx), .out_overflow(r16_ovf), .out_tag(r16_tag)
  );

  // Reference: exact magnitude, truncated quotient and remainder, then IEEE rounding. Returns {ovf, inx, bits}.
  function automatic logic [33:0] model(input logic [31:0] d, input bit sgn, input logic [1:0] rm,
                                        input int ew, input int mw);
    logic [63:0] mag, qt, rem, half, res;
    bit neg, up, inx, ovf, to_inf;
    int e, sh, be, emax;
    neg = sgn && d[31];
    mag = neg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    if (mag == 64'd0) return '0;
    e = 63;
    while (mag[e] == 1'b0) e--;
    rem = 0;
    half = 0;
    if (e > mw) begin
      sh   = e - mw;
      qt   = mag >> sh;
      rem  = mag - (qt << sh);
      half = 64'd1 << (sh - 1);
    end else begin
      qt = mag << (mw - e);
    end
    case (rm)
      2'd0:    up = (rem > half) || (rem == half && rem != 0 && qt[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = neg && rem != 0;
      default: up = !neg && rem != 0;
    endcase
    inx = rem != 0;
    qt = qt + 64'(up);
    if (qt >= (64'd1 << (mw + 1))) begin
      qt = qt >> 1;
      e++;
    end
    emax = (1 << ew) - 1;
    be   = e + (1 << (ew - 1)) - 1;
    ovf  = 1'b0;
    if (be >= emax) begin
      ovf = 1'b1;
      inx = 1'b1;
      to_inf = (rm == 2'd0) || (rm == 2'd2 && neg) || (rm == 2'd3 && !neg);
      if (to_inf) res = (64'(neg) << (ew + mw)) | (64'(emax) << mw);
      else        res = (64'(neg) << (ew + mw)) | (64'(emax - 1) << mw) | ((64'd1 << mw) - 1);
    end else begin
      res = (64'(neg) << (ew + mw)) | (64'(be) << mw) | (qt & ((64'd1 << mw) - 1));
    end
    return {ovf, inx, res[31:0]};
  endfunction

  function automatic logic [31:0] rnd_data();
    int k;
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 4095));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 4095));
      default: begin
        k = $urandom_range(0, 31);
        return (32'd1 << k) + 32'($urandom_range(0, 2)) - 32'd1;
      end
    endcase
  endfunction

  // Drives one beat with out_ready high and captures the first result from both formats.
  task automatic run_beat(input logic [31:0] d, input bit s, input logic [1:0] rm,
                          output logic [31:0] o32, output logic [15:0] o16,
                          output logic [1:0] f32, output logic [1:0] f16, output bit ok);
    @(negedge clk);
    out_ready = 1'b1;
    in_data = d;
    in_signed = s;
    in_rm = rm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0;
    o32 = '0; o16 = '0; f32 = '0; f16 = '0;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (r32_out_valid) begin
        o32 = r32_data; o16 = r16_data;
        f32 = {r32_ovf, r32_inx}; f16 = {r16_ovf, r16_inx};
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (r32_out_valid !== 1'b0 || r16_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b/%b want 0", r32_out_valid, r16_out_valid);
    end
    checks++;
    if (r32_in_ready !== 1'b1 || r16_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b/%b want 1", r32_in_ready, r16_in_ready);
    end
    checks++;
    if (r32_data !== 32'd0 || r16_data !== 16'd0) begin
      errors++; $display("FAIL reset_out_data got %h/%h want 0", r32_data, r16_data);
    end
    checks++;
    if ({r32_ovf, r32_inx, r16_ovf, r16_inx} !== 4'b0 || r32_tag !== 4'd0 || r16_tag !== 4'd0) begin
      errors++; $display("FAIL reset_flags_tag got %b%b%b%b tag %h/%h want 0", r32_ovf, r32_inx, r16_ovf, r16_inx, r32_tag, r16_tag);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    out_ready = 1'b1;
    in_data = 32'hFFFF_FFFF;
    in_signed = 1'b1;
    in_rm = 2'd0;
    in_tag = 4'h5;
    in_valid = 1'b1;
    #1;
    checks++;
    if (r32_in_ready !== 1'b1) begin
      errors++; $display("FAIL latency_in_ready got %b want 1", r32_in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r32_out_valid !== (k == 3)) begin
        errors++; $display("FAIL latency_valid cycle %0d got %b want %b", k + 1, r32_out_valid, k == 3);
      end
      if (k < 3) @(negedge clk);
    end
    checks++;
    if (r32_data !== 32'hBF80_0000 || {r32_ovf, r32_inx} !== 2'b00 || r32_tag !== 4'h5) begin
      errors++; $display("FAIL latency_result got %h fl %b tag %h want bf800000 fl 00 tag 5", r32_data, {r32_ovf, r32_inx}, r32_tag);
    end
  endtask

  task automatic test_fp32_directed();
    logic [31:0] dv [9] = '{32'hFFFF_FFFF, 32'h0100_0001, 32'h0100_0001, 32'h0100_0001, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFEFF_FFFF};
    bit          sv [9] = '{1, 0, 0, 0, 1, 0, 0, 1, 1};
    logic [1:0]  rv [9] = '{0, 0, 3, 1, 0, 0, 2, 2, 2};
    logic [31:0] ev [9] = '{32'hBF80_0000, 32'h4B80_0000, 32'h4B80_0001, 32'h4B80_0000, 32'hCF00_0000,
                            32'h4F80_0000, 32'h4F7F_FFFF, 32'h0000_0000, 32'hCB80_0001};
    logic [1:0]  fv [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    logic [31:0] o32; logic [15:0] o16; logic [1:0] f32, f16; bit ok;
    for (int i = 0; i < 9; i++) begin
      run_beat(dv[i], sv[i], rv[i], o32, o16, f32, f16, ok);
      checks++;
      if (!ok || o32 !== ev[i] || f32 !== fv[i]) begin
        errors++;
        $display("FAIL fp32_case%0d in=%h s=%0d rm=%0d got %h fl %b (seen %0d) want %h fl %b",
                 i, dv[i], sv[i], rv[i], o32, f32, ok, ev[i], fv[i]);
      end
    end
  endtask

  task automatic test_fp16_directed();
    logic [31:0] dv [9] = '{32'd65520, 32'd65520, 32'hFFFF_0010, 32'hFFFF_0010, 32'd1,
                            32'h8000_0000, 32'd2049, 32'd2049, 32'd65504};
    bit          sv [9] = '{0, 0, 1, 1, 0, 1, 0, 0, 0};
    logic [1:0]  rv [9] = '{0, 1, 2, 3, 0, 0, 0, 3, 0};
    logic [15:0] ev [9] = '{16'h7C00, 16'h7BFF, 16'hFC00, 16'hFBFF, 16'h3C00,
                            16'hFC00, 16'h6800, 16'h6801, 16'h7BFF};
    logic [1:0]  fv [9] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00};
    logic [31:0] o32; logic [15:0] o16; logic [1:0] f32, f16; bit ok;
    for (int i = 0; i < 9; i++) begin
      run_beat(dv[i], sv[i], rv[i], o32, o16, f32, f16, ok);
      checks++;
      if (!ok || o16 !== ev[i] || f16 !== fv[i]) begin
        errors++;
        $display("FAIL fp16_case%0d in=%h s=%0d rm=%0d got %h fl %b (seen %0d) want %h fl %b",
                 i, dv[i], sv[i], rv[i], o16, f16, ok, ev[i], fv[i]);
      end
    end
  endtask

  // Streams n random beats; with stall set, out_ready toggles randomly and held outputs must not move.
  task automatic test_stream(input int n, input bit stall, input string name);
    beat_t cur, b;
    int sent, got, cyc;
    bit held, acc;
    logic [31:0] h32; logic [15:0] h16; logic [3:0] htag;
    logic [33:0] e32, e16;
    sent = 0; got = 0; cyc = 0; held = 0; acc = 0;
    h32 = '0; h16 = '0; htag = '0;
    cur = '{d: 32'd0, s: 1'b0, rm: 2'd0, tag: 4'd0};
    q.delete();
    while ((sent < n || got < n) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        checks++;
        if (r32_out_valid !== 1'b1 || r32_data !== h32 || r16_data !== h16 || r32_tag !== htag) begin
          errors++;
          $display("FAIL %s hold got v=%b %h/%h tag %h want v=1 %h/%h tag %h",
                   name, r32_out_valid, r32_data, r16_data, r32_tag, h32, h16, htag);
        end
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (acc) begin
        in_valid = 1'b0;
        acc = 1'b0;
      end
      if (!in_valid && sent < n) begin
        cur.d = rnd_data();
        cur.s = 1'($urandom_range(0, 1));
        cur.rm = 2'($urandom_range(0, 3));
        cur.tag = 4'(sent);
        in_data = cur.d; in_signed = cur.s; in_rm = cur.rm; in_tag = cur.tag;
        in_valid = 1'b1;
      end
      #1;
      if (in_valid && r32_in_ready) begin
        q.push_back(cur);
        sent++;
        acc = 1'b1;
      end
      held = 1'b0;
      if (r32_out_valid) begin
        if (!out_ready) begin
          held = 1'b1;
          h32 = r32_data; h16 = r16_data; htag = r32_tag;
        end else if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s extra_result got %h tag %h want none", name, r32_data, r32_tag);
        end else begin
          b = q.pop_front();
          got++;
          e32 = model(b.d, b.s, b.rm, 8, 23);
          e16 = model(b.d, b.s, b.rm, 5, 10);
          checks++;
          if (r32_data !== e32[31:0] || {r32_ovf, r32_inx} !== e32[33:32] || r32_tag !== b.tag) begin
            errors++;
            $display("FAIL %s fp32 in=%h s=%0d rm=%0d got %h fl %b tag %h want %h fl %b tag %h",
                     name, b.d, b.s, b.rm, r32_data, {r32_ovf, r32_inx}, r32_tag, e32[31:0], e32[33:32], b.tag);
          end
          checks++;
          if (r16_data !== e16[15:0] || {r16_ovf, r16_inx} !== e16[33:32] || r16_tag !== b.tag) begin
            errors++;
            $display("FAIL %s fp16 in=%h s=%0d rm=%0d got %h fl %b tag %h want %h fl %b tag %h",
                     name, b.d, b.s, b.rm, r16_data, {r16_ovf, r16_inx}, r16_tag, e16[15:0], e16[33:32], b.tag);
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != n || q.size() != 0) begin
      errors++;
      $display("FAIL %s count got %0d results (%0d pending) want %0d", name, got, q.size(), n);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      in_data = rnd_data() | 32'd1;
      in_signed = 1'($urandom_range(0, 1));
      in_rm = 2'($urandom_range(0, 3));
      in_tag = 4'(9 + t);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (r32_out_valid !== 1'b0 || r16_out_valid !== 1'b0 || r32_in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_handshake got v=%b/%b rdy=%b want v=0 rdy=1", r32_out_valid, r16_out_valid, r32_in_ready);
    end
    checks++;
    if (r32_data !== 32'd0 || r16_data !== 16'd0 || r32_tag !== 4'd0) begin
      errors++; $display("FAIL midreset_data got %h/%h tag %h want 0", r32_data, r16_data, r32_tag);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (r32_out_valid || r16_out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_drop got %0d emerging beats want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fp32_directed();
    test_fp16_directed();
    test_stream(40, 1'b0, "back_to_back");
    test_stream(8, 1'b1, "backpressure");
    test_stream(30, 1'b1, "random_stall");
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
